multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Successor to the single-cycle decoder: a multicycle FSM controller for the RV32I subset addi, add/sub/and/or/slt, lw, sw, beq/bne.
- Sequences FETCH/DECODE/EXEC/MEM/WB over a shared-memory datapath.
- Stalls on a memory ready handshake, with a parametrised timeout.
- Traps on illegal encodings and halts until reset.

Parameters:
- MEM_TIMEOUT, 16, max cycles waiting for mem_ready in FETCH or MEM before trapping; 0 disables the timeout.
- CNT_WIDTH, 32, width of the retired-instruction counter (optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr  in  32  instruction register contents (datapath latches on ir_write).
- eq  in  1  ALU result zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  store request.
- adr_src  out  1  0 = PC address, 1 = ALU result address.
- ir_write  out  1  latch fetched word into IR.
- pc_write  out  1  update PC.
- pcsrc  out  1  0 = PC+4, 1 = old PC + branch immediate.
- regwrite  out  1  register file write enable.
- result_src  out  1  0 = ALU result, 1 = memory data.
- alusrc  out  1  0 = rs2, 1 = immediate.
- immsrc  out  2  00 = I, 01 = S, 10 = B.
- aluctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- halted  out  1  sticky trap indicator.
- trap_cause  out  2  00 none, 01 illegal, 10 timeout.
- retired  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Reset: rst_n low forces state RST. In RST every output is 0 and trap_cause is 00. The first clk edge after release moves to FETCH.
- Outputs are combinational from state, instr and mem_ready. Any output not listed for a state is 0.
- FETCH: mem_req=1, adr_src=0.
  - mem_ready=1: ir_write=1, pc_write=1, pcsrc=0, next DECODE.
  - mem_ready=0: stay in FETCH.
- DECODE: no outputs asserted.
  - opcode 19 with funct3 000 → EXEC.
  - opcode 51 with one of these → EXEC: funct7/funct3 00/000 add, 20/000 sub, 00/111 and, 00/110 or, 00/010 slt.
  - opcode 3 with funct3 010 → EXEC.
  - opcode 35 with funct3 010 → EXEC.
  - opcode 99 with funct3 000 or 001 → EXEC.
  - Anything else → TRAP, cause 01.
- EXEC:
  - addi: alusrc=1, immsrc=00, aluctrl=000, next WB.
  - R-type: alusrc=0, aluctrl per funct, next WB.
  - lw: alusrc=1, immsrc=00, aluctrl=000, next MEM.
  - sw: alusrc=1, immsrc=01, aluctrl=000, next MEM.
  - branch: alusrc=0, aluctrl=001, immsrc=10, pcsrc=1.
    - pc_write = (funct3==000 & eq) | (funct3==001 & !eq).
    - Next FETCH; the branch retires.
- MEM: mem_req=1, adr_src=1, mem_we=1 for sw.
  - mem_ready=1: lw → WB; sw → FETCH and retires.
  - mem_ready=0: stay in MEM.
- WB: regwrite=1, result_src=1 for lw and 0 otherwise, next FETCH, retires.
- Timeout: a wait counter clears on entry to FETCH or MEM and increments each cycle with mem_ready=0. When MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT-1 with mem_ready still 0, next state is TRAP with cause 10. mem_ready on that same cycle wins, so no trap.
- TRAP: all control outputs 0, halted=1, trap_cause held. Leaves TRAP only via reset.
- Reset mid-operation: abandons any request immediately; no write strobes are issued on the reset edge.
- CPI: alu 4, lw 5, sw 4, branch 3, each plus memory wait cycles.

Optional Feature:
- Macro PERF_COUNTER_EN.
- Defined: retired is a CNT_WIDTH register, reset to 0, incremented by 1 on each retire event listed above. Wraps from all-ones to 0. Frozen in TRAP.
- Undefined: retired tied to 0 and no counter flops are inferred.

Test Plan:
- Reset release, mem_ready=1, instr=addi x1,x0,5 (0x00500093) → FETCH, DECODE, EXEC (alusrc=1, aluctrl=000), WB regwrite=1; retired=1 after 4 cycles.
- bne with eq=0 (0xFE209EE3) → EXEC pc_write=1, pcsrc=1, immsrc=10. Repeat with eq=1 → pc_write=0. 3 cycles each.
- lw (0x0000A103) with mem_ready low 3 cycles in MEM → mem_req=1, adr_src=1 held for 4 cycles, then WB result_src=1, regwrite=1.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → TRAP after 4 cycles, halted=1, trap_cause=10, all strobes 0 until rst_n pulsed.
- instr=0xFFFFFFFF → DECODE → TRAP, trap_cause=01. Assert rst_n=0 asynchronously mid-cycle → outputs 0 immediately, restart in FETCH.
- sw (0x0020A023), mem_ready=1 → MEM mem_we=1, immsrc=01, then FETCH. With PERF_COUNTER_EN defined, retired increments; undefined, retired=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle FSM controller for the RV32I subset addi, add/sub/and/or/slt, lw, sw, beq/bne.
// Define PERF_COUNTER_EN to build the retired-instruction counter; otherwise o_retired is tied to 0.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          i_instr,
    input  logic                 i_eq,
    input  logic                 i_mem_ready,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic                 o_adr_src,
    output logic                 o_ir_write,
    output logic                 o_pc_write,
    output logic                 o_pcsrc,
    output logic                 o_regwrite,
    output logic                 o_result_src,
    output logic                 o_alusrc,
    output logic [1:0]           o_immsrc,
    output logic [2:0]           o_aluctrl,
    output logic                 o_halted,
    output logic [1:0]           o_trap_cause,
    output logic [CNT_WIDTH-1:0] o_retired
);
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

    state_t        r_state, w_next;
    logic [1:0]    r_cause, w_cause;
    logic [WW-1:0] r_wait;
    logic [6:0]    w_op, w_f7;
    logic [2:0]    w_f3, w_r_alu;
    logic          w_addi, w_rtype, w_lw, w_sw, w_br, w_legal, w_timeout;
    logic          w_unused;

    assign w_op      = i_instr[6:0];
    assign w_f3      = i_instr[14:12];
    assign w_f7      = i_instr[31:25];
    assign w_unused  = ^{i_instr[24:15], i_instr[11:7]};
    assign w_addi    = w_op == 7'd19 && w_f3 == 3'b000;
    assign w_rtype   = w_op == 7'd51 && ((w_f7 == 7'h00 && (w_f3 == 3'b000 || w_f3 == 3'b111 ||
                       w_f3 == 3'b110 || w_f3 == 3'b010)) || (w_f7 == 7'h20 && w_f3 == 3'b000));
    assign w_lw      = w_op == 7'd3 && w_f3 == 3'b010;
    assign w_sw      = w_op == 7'd35 && w_f3 == 3'b010;
    assign w_br      = w_op == 7'd99 && (w_f3 == 3'b000 || w_f3 == 3'b001);
    assign w_legal   = w_addi || w_rtype || w_lw || w_sw || w_br;
    assign w_r_alu   = w_f3 == 3'b111 ? 3'b010 : w_f3 == 3'b110 ? 3'b011 :
                       w_f3 == 3'b010 ? 3'b101 : {2'b00, w_f7[5]};
    assign w_timeout = MEM_TIMEOUT != 0 && !i_mem_ready && r_wait == WAIT_LAST;

    always_comb begin
        w_next       = r_state;
        w_cause      = r_cause;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_adr_src    = 1'b0;
        o_ir_write   = 1'b0;
        o_pc_write   = 1'b0;
        o_pcsrc      = 1'b0;
        o_regwrite   = 1'b0;
        o_result_src = 1'b0;
        o_alusrc     = 1'b0;
        o_immsrc     = 2'b00;
        o_aluctrl    = 3'b000;
        o_halted     = 1'b0;
        case (r_state)
            S_RST: w_next = S_FETCH;
            S_FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_next  = S_TRAP;
                    w_cause = 2'b10;
                end
            end
            S_DECODE: begin
                w_next  = w_legal ? S_EXEC : S_TRAP;
                w_cause = w_legal ? r_cause : 2'b01;
            end
            S_EXEC: begin
                o_alusrc   = !(w_rtype || w_br);
                o_immsrc   = w_sw ? 2'b01 : w_br ? 2'b10 : 2'b00;
                o_aluctrl  = w_rtype ? w_r_alu : w_br ? 3'b001 : 3'b000;
                o_pcsrc    = w_br;
                // funct3[0] selects bne, which takes the branch when eq is low
                o_pc_write = w_br && (w_f3[0] ^ i_eq);
                w_next     = w_br ? S_FETCH : (w_lw || w_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                o_mem_req = 1'b1;
                o_adr_src = 1'b1;
                o_mem_we  = w_sw;
                if (i_mem_ready) begin
                    w_next = w_lw ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_next  = S_TRAP;
                    w_cause = 2'b10;
                end
            end
            S_WB: begin
                o_regwrite   = 1'b1;
                o_result_src = w_lw;
                w_next       = S_FETCH;
            end
            S_TRAP: o_halted = 1'b1;
            default: w_next = S_RST;
        endcase
    end

    assign o_trap_cause = r_cause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RST;
            r_cause <= 2'b00;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
            // staying in FETCH/MEM only happens while mem_ready is low
            if (w_next != r_state)
                r_wait <= '0;
            else if (r_state == S_FETCH || r_state == S_MEM)
                r_wait <= r_wait + WW'(1);
        end
    end

`ifdef PERF_COUNTER_EN
    logic                 w_retire;
    logic [CNT_WIDTH-1:0] r_retired;

    assign w_retire = (r_state == S_EXEC && w_br) || (r_state == S_MEM && i_mem_ready && w_sw) ||
                      r_state == S_WB;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_retired <= '0;
        else if (w_retire)
            r_retired <= r_retired + CNT_WIDTH'(1);
    end

    assign o_retired = r_retired;
`else
    assign o_retired = '0;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench; the driver plans each instruction's cycles from the ISA rules and
// queues the expected control vector per cycle, the monitor pops and compares at every falling edge.
module tb_multicycle_control_unit;
    localparam int TO = 4;
    localparam int C_ILL = 0, C_ADDI = 1, C_R = 2, C_LW = 3, C_SW = 4, C_BR = 5;

    typedef struct packed {
        logic       mem_req, mem_we, adr_src, ir_write, pc_write, pcsrc, regwrite, result_src, alusrc;
        logic [1:0] immsrc;
        logic [2:0] aluctrl;
        logic       halted;
        logic [1:0] cause;
    } ctl_t;

    typedef struct {
        ctl_t        c;
        logic [31:0] ret;
        string       tag;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, eq = 1'b0, mem_ready = 1'b0;
    logic [31:0] instr = '0;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, pcsrc, regwrite, result_src, alusrc, halted;
    logic [1:0]  immsrc, trap_cause;
    logic [2:0]  aluctrl;
    logic [31:0] retired;
    ctl_t        act;
    exp_t        q[$];
    exp_t        me;
    int          compared = 0, mismatched = 0;
    logic [31:0] n_ret = '0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEM_TIMEOUT(TO), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_instr(instr), .i_eq(eq), .i_mem_ready(mem_ready),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_adr_src(adr_src), .o_ir_write(ir_write),
        .o_pc_write(pc_write), .o_pcsrc(pcsrc), .o_regwrite(regwrite), .o_result_src(result_src),
        .o_alusrc(alusrc), .o_immsrc(immsrc), .o_aluctrl(aluctrl), .o_halted(halted),
        .o_trap_cause(trap_cause), .o_retired(retired)
    );

    assign act = {mem_req, mem_we, adr_src, ir_write, pc_write, pcsrc, regwrite, result_src, alusrc,
                  immsrc, aluctrl, halted, trap_cause};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            compared++;
            if (act !== me.c || retired !== me.ret) begin
                mismatched++;
                $display("FAIL %s @%0t: got ctl=%h retired=%0d, want ctl=%h retired=%0d",
                         me.tag, $time, act, retired, me.c, me.ret);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic push(input ctl_t c, input string tag);
        exp_t x;
        x.c   = c;
        x.tag = tag;
`ifdef PERF_COUNTER_EN
        x.ret = n_ret;
`else
        x.ret = '0;
`endif
        q.push_back(x);
    endtask

    task automatic cyc(input logic mr, input logic e, input logic [31:0] ins, input ctl_t c, input string tag);
        @(posedge clk);
        #1;
        mem_ready = mr;
        eq        = e;
        instr     = ins;
        push(c, tag);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        mem_ready = rb();
        eq        = rb();
        n_ret     = '0;
        push('0, "reset_async");
        cyc(rb(), rb(), instr, '0, "reset_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push('0, "rst_state");
    endtask

    task automatic trap(input logic [1:0] cause, input logic [31:0] ins);
        ctl_t c;
        c        = '0;
        c.halted = 1'b1;
        c.cause  = cause;
        for (int k = 0; k < 3; k++)
            cyc(rb(), rb(), ins, c, cause == 2'b01 ? "trap_illegal" : "trap_timeout");
        do_reset();
    endtask

    function automatic int classify(input logic [31:0] ins, output logic [2:0] alu);
        logic [6:0] op, f7;
        logic [2:0] f3;
        op  = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        alu = 3'b000;
        if (op == 7'd19 && f3 == 3'd0) return C_ADDI;
        if (op == 7'd51 && f7 == 7'h00 && f3 == 3'd0) begin alu = 3'b000; return C_R; end
        if (op == 7'd51 && f7 == 7'h20 && f3 == 3'd0) begin alu = 3'b001; return C_R; end
        if (op == 7'd51 && f7 == 7'h00 && f3 == 3'd7) begin alu = 3'b010; return C_R; end
        if (op == 7'd51 && f7 == 7'h00 && f3 == 3'd6) begin alu = 3'b011; return C_R; end
        if (op == 7'd51 && f7 == 7'h00 && f3 == 3'd2) begin alu = 3'b101; return C_R; end
        if (op == 7'd3 && f3 == 3'd2) return C_LW;
        if (op == 7'd35 && f3 == 3'd2) return C_SW;
        if (op == 7'd99 && (f3 == 3'd0 || f3 == 3'd1)) return C_BR;
        return C_ILL;
    endfunction

    // eqsel: 0/1 forces the ALU zero flag in EXEC, 2 randomizes it; abort resets on the first ready MEM cycle
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int eqsel, input bit abort);
        ctl_t       c;
        logic [2:0] alu;
        int         cls;
        logic       e;
        cls = classify(ins, alu);
        for (int i = 0; i < fw; i++) begin
            c = '0;
            c.mem_req = 1'b1;
            cyc(1'b0, rb(), ins, c, "fetch_wait");
            if (i == TO - 1) begin trap(2'b10, ins); return; end
        end
        c = '0;
        c.mem_req  = 1'b1;
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
        cyc(1'b1, rb(), ins, c, "fetch");
        cyc(rb(), rb(), ins, '0, "decode");
        if (cls == C_ILL) begin trap(2'b01, ins); return; end
        e = (eqsel == 2) ? rb() : 1'(eqsel);
        c = '0;
        case (cls)
            C_ADDI: c.alusrc = 1'b1;
            C_R:    c.aluctrl = alu;
            C_LW:   c.alusrc = 1'b1;
            C_SW:   begin c.alusrc = 1'b1; c.immsrc = 2'b01; end
            default: begin
                c.aluctrl  = 3'b001;
                c.immsrc   = 2'b10;
                c.pcsrc    = 1'b1;
                c.pc_write = (ins[14:12] == 3'd0 && e) || (ins[14:12] == 3'd1 && !e);
            end
        endcase
        cyc(rb(), e, ins, c, "exec");
        if (cls == C_BR) begin n_ret++; return; end
        if (cls == C_LW || cls == C_SW) begin
            c = '0;
            c.mem_req = 1'b1;
            c.adr_src = 1'b1;
            c.mem_we  = (cls == C_SW);
            for (int i = 0; i < mw; i++) begin
                cyc(1'b0, rb(), ins, c, "mem_wait");
                if (i == TO - 1) begin trap(2'b10, ins); return; end
            end
            if (abort) begin do_reset(); return; end
            cyc(1'b1, rb(), ins, c, "mem");
            if (cls == C_SW) begin n_ret++; return; end
        end
        c = '0;
        c.regwrite   = 1'b1;
        c.result_src = (cls == C_LW);
        cyc(rb(), rb(), ins, c, "wb");
        n_ret++;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  f7s[5];
        logic [2:0]  f3s[5];
        logic [6:0]  ops[5];
        int          k;
        r   = $urandom;
        f7s = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00};
        f3s = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd2};
        ops = '{7'd19, 7'd51, 7'd3, 7'd35, 7'd99};
        k   = int'($urandom_range(4));
        case ($urandom_range(7))
            0: return {r[31:15], 3'b000, r[11:7], 7'd19};
            1: return {f7s[k], r[24:15], f3s[k], r[11:7], 7'd51};
            2: return {r[31:15], 3'b010, r[11:7], 7'd3};
            3: return {r[31:15], 3'b010, r[11:7], 7'd35};
            4: return {r[31:15], 2'b00, r[12], r[11:7], 7'd99};
            5: return {r[31:7], ops[k]};
            default: return r;
        endcase
    endfunction

    initial begin
        do_reset();
        run_instr(32'h00500093, 0, 0, 2, 1'b0);
        run_instr(32'hFE209EE3, 0, 0, 0, 1'b0);
        run_instr(32'hFE209EE3, 0, 0, 1, 1'b0);
        run_instr(32'h00208463, 0, 0, 1, 1'b0);
        run_instr(32'h00208463, 0, 0, 0, 1'b0);
        run_instr(32'h0000A103, 0, 3, 2, 1'b0);
        run_instr(32'h402081B3, 1, 0, 2, 1'b0);
        run_instr(32'h0020A1B3, 0, 0, 2, 1'b0);
        run_instr(32'h0000A103, TO - 1, TO - 1, 2, 1'b0);
        run_instr(32'h00500093, TO, 0, 2, 1'b0);
        run_instr(32'hFFFFFFFF, 0, 0, 2, 1'b0);
        run_instr(32'h0020A023, 0, 0, 2, 1'b0);
        run_instr(32'h0020A023, 1, 0, 2, 1'b1);
        run_instr(32'h0020A023, 0, 0, 2, 1'b0);
        run_instr(32'h0000A103, 0, TO, 2, 1'b0);
        for (int n = 0; n < 300; n++) begin
            int fw, mw;
            fw = ($urandom_range(7) == 0) ? TO : int'($urandom_range(2));
            mw = ($urandom_range(7) == 0) ? TO : int'($urandom_range(3));
            run_instr(rand_instr(), fw, mw, 2, $urandom_range(30) == 0);
        end
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
